dmd_scan: RTL

DMD_SCAN -- requirements
Module: dmd_scan

---
 rtl/dmd_scan_pkg.sv | 23 ++
 rtl/dmd_scan_if.sv | 13 +
 rtl/dmd_framebuf.sv | 57 +++++
 rtl/dmd_scan.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/dmd_scan_pkg.sv
// Shared definitions for the DMD row scanner: FSM encoding, geometry and
// default timing.
package dmd_scan_pkg;

  localparam int ROW_W     = 4;
  localparam int COL_W     = 16;
  localparam int NUM_ROWS  = 16;
  localparam int CNT_W     = 16;
  localparam int DWELL_DEF = 1024;
  localparam int BLANK_DEF = 4;

  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  // Next row index; 15 wraps to 0 through natural overflow of the row width.
  function automatic logic [ROW_W-1:0] row_inc(input logic [ROW_W-1:0] row);
    return row + 4'd1;
  endfunction

endpackage

// File: rtl/dmd_scan_if.sv
// Frame-buffer write port and swap handshake of the DMD scanner.
interface dmd_scan_if;
  import dmd_scan_pkg::*;

  logic             wr_en;
  logic [ROW_W-1:0] wr_row;
  logic [COL_W-1:0] wr_data;
  logic             swap_req;
  logic             swap_ack;

  modport master (output wr_en, wr_row, wr_data, swap_req, input swap_ack);
  modport slave  (input wr_en, wr_row, wr_data, swap_req, output swap_ack);
endinterface

// File: rtl/dmd_framebuf.sv
// Double-buffered 16x16 frame store: writes land in the back bank, the scan
// reads the front bank, and a toggle exchanges the roles of the two banks.
module dmd_framebuf
  import dmd_scan_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_wr_en,
  input  logic [ROW_W-1:0] i_wr_row,
  input  logic [COL_W-1:0] i_wr_data,
  input  logic             i_toggle,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic [COL_W-1:0] o_rd_data
);

  // r_sel = 0: bank0 is front, bank1 is back; r_sel = 1: the reverse.
  logic                            r_sel;
  logic [NUM_ROWS-1:0][COL_W-1:0]  r_bank0;
  logic [NUM_ROWS-1:0][COL_W-1:0]  r_bank1;

  // Front-bank select; flips only at a committed swap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sel <= 1'b0;
    end else if (i_toggle) begin
      r_sel <= ~r_sel;
    end else begin
      r_sel <= r_sel;
    end
  end

  // Bank 0 storage; writable only while it is the back bank. A write on the
  // swap edge uses the pre-swap select, so it lands in the bank becoming front.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank0 <= {(NUM_ROWS*COL_W){1'b0}};
    end else if (i_wr_en && r_sel) begin
      r_bank0[i_wr_row] <= i_wr_data;
    end else begin
      r_bank0 <= r_bank0;
    end
  end

  // Bank 1 storage; writable only while it is the back bank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank1 <= {(NUM_ROWS*COL_W){1'b0}};
    end else if (i_wr_en && !r_sel) begin
      r_bank1[i_wr_row] <= i_wr_data;
    end else begin
      r_bank1 <= r_bank1;
    end
  end

  assign o_rd_data = r_sel ? r_bank1[i_rd_row] : r_bank0[i_rd_row];

endmodule

// File: rtl/dmd_scan.sv
// Row scanner for a 16x16 dot-matrix display: blanks, latches and shows each
// row in turn from the front frame buffer, and swaps buffers at frame end.
module dmd_scan
  import dmd_scan_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic             CLK,
  input  logic             RESET,
  dmd_scan_if.slave        bus,
  output logic             frame_start,
  output logic [ROW_W-1:0] dmd_seg,
  output logic [COL_W-1:0] dmd_column,
  output logic             DMD_CLK,
  output logic             DMD_CLR
);

  localparam logic [CNT_W-1:0] DWELL_C  = CNT_W'(DWELL);
  localparam logic [CNT_W-1:0] BLANK_C  = CNT_W'(BLANK);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  // r_cnt holds the number of cycles already spent in the current state.
  // It is 0 only straight out of reset, which marks the reset-exit entry
  // into BLANK of row 0 (reset time itself does not count as blanking).
  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic             r_pend, w_pend_nxt;
  logic             w_swap;
  logic             w_frame_start_nxt;
  logic [COL_W-1:0] w_front_col;

  logic [ROW_W-1:0] r_seg, w_seg_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic             r_clk, w_clk_nxt;
  logic             r_clr, w_clr_nxt;
  logic             r_frame_start;
  logic             r_swap_ack;

  dmd_framebuf u_framebuf (
    .i_clk     (CLK),
    .i_rst_n   (RESET),
    .i_wr_en   (bus.wr_en),
    .i_wr_row  (bus.wr_row),
    .i_wr_data (bus.wr_data),
    .i_toggle  (w_swap),
    .i_rd_row  (r_row),
    .o_rd_data (w_front_col)
  );

  // Next-state, counter, row, swap and pending-flag logic.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_row_nxt         = r_row;
    w_swap            = 1'b0;
    w_frame_start_nxt = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_frame_start_nxt = 1'b1;
        end else begin
          w_frame_start_nxt = 1'b0;
        end
        if (r_cnt >= BLANK_C) begin
          w_state_nxt = ST_LATCH;
          w_cnt_nxt   = 16'd1;
        end else begin
          w_cnt_nxt   = r_cnt + 16'd1;
        end
      end
      ST_LATCH: begin
        w_state_nxt = ST_SHOW;
        w_cnt_nxt   = 16'd1;
      end
      ST_SHOW: begin
        if (r_cnt >= DWELL_C) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = 16'd1;
          w_row_nxt   = row_inc(r_row);
          if (r_row == LAST_ROW) begin
            // Frame boundary: a request arriving on this very edge is
            // folded into this swap rather than re-arming the flag.
            w_frame_start_nxt = 1'b1;
            w_swap            = r_pend | bus.swap_req;
          end else begin
            w_frame_start_nxt = 1'b0;
          end
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = 16'd0;
        w_row_nxt   = 4'd0;
      end
    endcase

    if (w_swap) begin
      w_pend_nxt = 1'b0;
    end else if (bus.swap_req) begin
      w_pend_nxt = 1'b1;
    end else begin
      w_pend_nxt = r_pend;
    end
  end

  // Driver outputs decoded from the state being entered, so they register
  // in step with it.
  always_comb begin
    w_seg_nxt = r_seg;
    w_col_nxt = r_col;
    w_clk_nxt = 1'b0;
    w_clr_nxt = 1'b1;
    case (w_state_nxt)
      ST_BLANK: begin
        w_seg_nxt = w_row_nxt;
        w_col_nxt = 16'h0000;
        w_clk_nxt = 1'b0;
        w_clr_nxt = 1'b1;
      end
      ST_LATCH: begin
        w_seg_nxt = r_row;
        w_col_nxt = w_front_col;
        w_clk_nxt = 1'b1;
        w_clr_nxt = 1'b0;
      end
      ST_SHOW: begin
        w_seg_nxt = r_seg;
        w_col_nxt = r_col;
        w_clk_nxt = 1'b0;
        w_clr_nxt = 1'b0;
      end
      default: begin
        w_seg_nxt = 4'd0;
        w_col_nxt = 16'h0000;
        w_clk_nxt = 1'b0;
        w_clr_nxt = 1'b1;
      end
    endcase
  end

  // FSM state, dwell/blank counter, row index and pending swap flag.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_BLANK;
      r_cnt   <= 16'd0;
      r_row   <= 4'd0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  // Registered matrix-driver outputs and status pulses.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_seg         <= 4'd0;
      r_col         <= 16'h0000;
      r_clk         <= 1'b0;
      r_clr         <= 1'b1;
      r_frame_start <= 1'b0;
      r_swap_ack    <= 1'b0;
    end else begin
      r_seg         <= w_seg_nxt;
      r_col         <= w_col_nxt;
      r_clk         <= w_clk_nxt;
      r_clr         <= w_clr_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_swap_ack    <= w_swap;
    end
  end

  assign dmd_seg      = r_seg;
  assign dmd_column   = r_col;
  assign DMD_CLK      = r_clk;
  assign DMD_CLR      = r_clr;
  assign frame_start  = r_frame_start;
  assign bus.swap_ack = r_swap_ack;

endmodule
